// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: wide add on a shared external 4-bit adder, LSB nibble first.
// Define NIBBLE_ADD_SUB_EN to add a 'sub' input that selects A-B (carry_out=1 means no borrow).
module nibble_add_sequencer #(
  parameter int NUM_NIBBLES = 4,
  localparam int W = 4 * NUM_NIBBLES
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         carry_in,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_overflow,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out
);

  localparam int IW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;

  logic [IW-1:0] idx_d;
  logic          last_d;
  logic          cin_d;
  logic [3:0]    a_nib_d;
  logic [3:0]    b_nib_d;

`ifdef NIBBLE_ADD_SUB_EN
  logic          sub_q;
`endif

  assign idx_d  = idx_q + IW'(1);
  assign last_d = (idx_q == IW'(NUM_NIBBLES - 1));

  // Initial carry: subtraction forces a 1 so that ~B + 1 forms -B
  always_comb begin
    cin_d = carry_in;
`ifdef NIBBLE_ADD_SUB_EN
    if (sub) cin_d = 1'b1;
`endif
  end

  // Pick the operand nibbles addressed by the current index
  always_comb begin
    a_nib_d = '0;
    b_nib_d = '0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib_d = a_q[4*i +: 4];
        b_nib_d = b_q[4*i +: 4];
      end
    end
  end

  // Drive the shared adder only while adding; idle it otherwise
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_ADD) begin
      add_a   = a_nib_d;
      add_b   = b_nib_d;
`ifdef NIBBLE_ADD_SUB_EN
      if (sub_q) add_b = ~b_nib_d;
`endif
      add_cin = carry_q;
    end
  end

  // Control FSM with operand, carry and result registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            carry_q  <= cin_d;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
            sub_q    <= sub;
`endif
            state_q  <= S_ADD;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NUM_NIBBLES; i++) begin
            if (idx_q == IW'(i)) result_q[4*i +: 4] <= add_sum;
          end
          carry_q <= add_overflow;
          if (last_d) begin
            cout_q  <= add_overflow;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
- Multi-cycle controller that computes a wide sum by time-multiplexing one shared adder_4bit instance.
- Operands are processed one 4-bit nibble per cycle, LSB nibble first, with the carry held in a register between nibbles.
- The adder_4bit instance lives outside this block; this block drives its a/b/carry_in and samples its sum/overflow.
- Sits between a requester (start/done handshake) and the adder datapath.

Parameters:
NUM_NIBBLES, 4, number of 4-bit slices per operand; W = 4*NUM_NIBBLES (default 16); must be >= 2.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
op_a  input  W  operand A; sampled on the accepting edge
op_b  input  W  operand B; sampled on the accepting edge
carry_in  input  1  initial carry; sampled on the accepting edge
add_a  output  4  nibble of A driven to the shared adder
add_b  output  4  nibble of B driven to the shared adder
add_cin  output  1  carry driven to the shared adder
add_sum  input  4  adder sum (combinational, same cycle)
add_overflow  input  1  adder carry-out (combinational, same cycle)
busy  output  1  high in ADD and DONE states
done  output  1  one-cycle pulse when result is valid
result  output  W  final sum; held until the next accepted start
carry_out  output  1  final carry; held with result

Behaviour:
- Single clock clk; asynchronous, active-low reset n_rst.
- Reset values: state=IDLE, index=0, carry_reg=0, operand regs=0, result=0, carry_out=0, busy=0, done=0.
- Adder drive outputs add_a/add_b/add_cin are 0 whenever state != ADD.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start=1 -> latch op_a, op_b into internal regs; carry_reg<=carry_in; index<=0; clear result and carry_out; go to ADD.
  - start=0 -> stay in IDLE.
- ADD:
  - add_a = a_reg[4*index+:4]; add_b = b_reg[4*index+:4]; add_cin = carry_reg.
  - On each edge: result[4*index+:4] <= add_sum; carry_reg <= add_overflow.
  - If index == NUM_NIBBLES-1: carry_out <= add_overflow and go to DONE; otherwise index <= index+1.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: with start sampled at edge k, ADD occupies cycles k..k+N-1 (N = NUM_NIBBLES), and done is high in the cycle following edge k+N.
  - Minimum back-to-back spacing is N+2 edges.
- start while busy (ADD or DONE): ignored; no latching, no effect on the result in progress.
- Operand inputs may change after acceptance without effect.
- Wrap-around: the final carry goes only to carry_out; result is W bits modulo 2^W.
- Reset asserted mid-operation: immediate return to reset values, and the partial result is discarded.
- result is updated nibble-by-nibble during ADD. Consumers must read result only when done=1 or after it.

Optional Feature:
- Macro: NIBBLE_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, the block computes A-B: add_b = ~b_reg nibble, and the initial carry_reg is forced to 1 regardless of carry_in.
  - carry_out=1 means no borrow.
- Not defined: no sub port; the block is addition only.

Test Plan (NUM_NIBBLES=4):
1. op_a=0x1234, op_b=0x1111, carry_in=0, start pulse -> busy for 5 cycles; done at the 5th edge after acceptance; result=0x2345; carry_out=0.
2. op_a=0xFFFF, op_b=0x0001, carry_in=0 -> carry ripples through all 4 ADD cycles; result=0x0000; carry_out=1. Checker confirms add_cin=1 in ADD cycles 2-4.
3. op_a=0xFFFF, op_b=0xFFFF, carry_in=1 -> result=0xFFFF, carry_out=1. Then an immediate second start with 0x0000+0x0000, cin=0 -> result=0x0000, carry_out=0.
4. Start 0x00FF+0x0001, then assert start with 0xAAAA/0x5555 during ADD cycle 2 -> second request ignored; result=0x0100; only one done pulse.
5. Start 0x1234+0x4321, then drop n_rst low asynchronously mid-ADD (index=2) -> result=0, carry_out=0, busy=0, done=0, add_* outputs 0. After release, a new start of 0x0001+0x0001 yields 0x0002.
6. (NIBBLE_ADD_SUB_EN) sub=1, op_a=0x0005, op_b=0x0007 -> result=0xFFFE, carry_out=0. Then sub=1, 0x0007-0x0005 -> result=0x0002, carry_out=1.
